// File: rtl/i2c_flag_wr.sv
// Single-shot I2C master write: a wr_en rising edge sends START, {DEV_ADDR,W}, register
// address, data byte and STOP, with open-drain SDA and push-pull SCL.
module i2c_flag_wr #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter logic [6:0] DEV_ADDR     = 7'h50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_done,
  output logic       ack_err
);

  localparam int Q  = SYS_CLK_FREQ / (SCL_FREQ * 4);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(Q - 1);

  typedef enum logic [3:0] {
    IDLE, START, SEND_DEV, ACK1, SEND_ADDR, ACK2, SEND_DATA, ACK3, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            ack_err_q, ack_err_d;
  logic            wr_done_q, wr_done_d;
  logic            wr_en_q, wr_en_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;

  logic sda_in;
  logic tick;
  logic req;
  logic is_ack;

  assign sda_in = sda;
  assign tick   = (cnt_q == CNT_MAX);
  assign req    = wr_en & ~wr_en_q;
  assign is_ack = (state_q == ACK1) || (state_q == ACK2) || (state_q == ACK3);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      ack_err_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_en_q   <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
      wr_done_q <= wr_done_d;
      wr_en_q   <= wr_en_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    wr_done_d = 1'b0;
    wr_en_d   = wr_en;
    if (state_q == IDLE) begin
      cnt_d   = '0;
      phase_d = 2'd0;
      bit_d   = 3'd0;
      if (req) begin
        addr_d    = wr_addr;
        data_d    = wr_data;
        ack_err_d = 1'b0;
        shift_d   = {DEV_ADDR, 1'b0};
        state_d   = START;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd2 && is_ack && sda_in)
          ack_err_d = 1'b1;
        // Every state decision happens at the end of the fourth quarter of a bit slot
        if (phase_q == 2'd3) begin
          case (state_q)
            START: state_d = SEND_DEV;
            SEND_DEV, SEND_ADDR, SEND_DATA: begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                case (state_q)
                  SEND_DEV:  state_d = ACK1;
                  SEND_ADDR: state_d = ACK2;
                  default:   state_d = ACK3;
                endcase
              end
            end
            ACK1: begin
              shift_d = addr_q;
              state_d = ack_err_q ? STOP : SEND_ADDR;
            end
            ACK2: begin
              shift_d = data_q;
              state_d = ack_err_q ? STOP : SEND_DATA;
            end
            ACK3: state_d = STOP;
            STOP: begin
              state_d   = IDLE;
              wr_done_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Pin levels are decoded from state/phase and registered so the bus never sees decode glitches
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_q)
      START: begin
        scl_d     = (phase_q != 2'd3);
        sda_low_d = phase_q[1];
      end
      SEND_DEV, SEND_ADDR, SEND_DATA: begin
        scl_d     = phase_q[0] ^ phase_q[1];
        sda_low_d = ~shift_q[7];
      end
      ACK1, ACK2, ACK3: begin
        scl_d = phase_q[0] ^ phase_q[1];
      end
      STOP: begin
        scl_d     = (phase_q != 2'd0);
        sda_low_d = ~phase_q[1];
      end
      default: ;
    endcase
  end

  assign scl     = scl_q;
  assign sda     = sda_low_q ? 1'b0 : 1'bz;
  assign busy    = (state_q != IDLE);
  assign wr_done = wr_done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_flag_wr.sv
// Bench for i2c_flag_wr: bus monitor with ACK/NACK slave, scoreboard checked on wr_done,
// table of write vectors plus drop, hold-high and mid-transfer reset sequences.
module tb_i2c_flag_wr;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       scl, busy, wr_done, ack_err;
  wire        sda;
  logic       slv_drive = 1'b0;

  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;

  i2c_flag_wr dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .wr_done  (wr_done),
    .ack_err  (ack_err)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         nack;
    bit         exp_err;
    int         exp_nbytes;
    int         exp_busy;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor and slave ----------------
  bit         slave_nack_dev = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  bit         in_xfer = 1'b0;
  int         bitidx = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] bytes [3];
  int         nbytes = 0;
  logic [7:0] snap_b [3];
  int         snap_n = 0;
  int         stop_cnt = 0;
  int         proto_err = 0;
  int         cyc = 0;
  int         last_rise = 0, last_fall = 0;
  bit         seen_rise = 1'b0, seen_fall = 1'b0;

  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      in_xfer = 1'b0; bitidx = 0; nbytes = 0; slv_drive = 1'b0;
      scl_p = 1'b1; sda_p = 1'b1; seen_rise = 1'b0; seen_fall = 1'b0;
    end else begin
      if (!busy) begin
        seen_rise = 1'b0;
        seen_fall = 1'b0;
      end
      if (scl && scl_p && sda != sda_p) begin
        if (!sda) begin
          if (in_xfer) proto_err++;
          in_xfer = 1'b1; bitidx = 0; nbytes = 0;
        end else begin
          if (!in_xfer) proto_err++;
          in_xfer = 1'b0;
          snap_n = nbytes;
          for (int i = 0; i < 3; i++) snap_b[i] = bytes[i];
          stop_cnt++;
        end
      end
      if (scl && !scl_p) begin
        if (seen_fall) check("scl_low_width", cyc - last_fall, 100);
        last_rise = cyc;
        seen_rise = seen_fall;
        if (in_xfer) begin
          if (bitidx < 8) sh = {sh[6:0], sda};
          bitidx++;
          if (bitidx == 8) begin
            if (nbytes < 3) bytes[nbytes] = sh;
            nbytes++;
          end
        end
      end
      if (!scl && scl_p) begin
        if (seen_rise) check("scl_high_width", cyc - last_rise, 100);
        last_fall = cyc;
        seen_fall = 1'b1;
        if (in_xfer) begin
          if (bitidx == 8) slv_drive = !(slave_nack_dev && nbytes == 1);
          else if (bitidx == 9) begin
            slv_drive = 1'b0;
            bitidx = 0;
          end
        end
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  // ---------------- scoreboard on wr_done ----------------
  vec_t exp_q [$];
  int   done_cnt = 0;
  int   busy_cnt = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (wr_done) begin
        vec_t e;
        done_cnt++;
        check("busy_low_at_done", busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("nbytes", snap_n, e.exp_nbytes);
          check("dev_byte", snap_b[0], 8'hA0);
          if (e.exp_nbytes == 3) begin
            check("addr_byte", snap_b[1], e.addr);
            check("data_byte", snap_b[2], e.data);
          end
          check("ack_err", ack_err, e.exp_err);
          check("busy_len_ok", (busy_cnt >= e.exp_busy - 2 && busy_cnt <= e.exp_busy + 2), 1);
          $display("xfer addr=%02h data=%02h nack=%0d bytes=%0d ack_err=%0d busy=%0d",
                   e.addr, e.data, e.nack, snap_n, ack_err, busy_cnt);
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input vec_t v, input bit expect_out);
    slave_nack_dev = v.nack;
    wr_addr = v.addr;
    wr_data = v.data;
    if (expect_out) exp_q.push_back(v);
    @(negedge sys_clk);
    wr_en = 1'b1;
    cycles(5);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt == start_cnt) check("done_timeout", 0, 1);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] d, input bit nack);
    vec_t v;
    v.addr = a;
    v.data = d;
    v.nack = nack;
    v.exp_err = nack;
    v.exp_nbytes = nack ? 1 : 3;
    v.exp_busy = nack ? 2200 : 5800;
    return v;
  endfunction

  vec_t tbl [4];

  initial begin
    int d0;
    int s0;
    int n;
    tbl[0] = '{addr: 8'h12, data: 8'hA5, nack: 1'b0, exp_err: 1'b0, exp_nbytes: 3, exp_busy: 5800};
    tbl[1] = '{addr: 8'h00, data: 8'hFF, nack: 1'b1, exp_err: 1'b1, exp_nbytes: 1, exp_busy: 2200};
    tbl[2] = '{addr: 8'hFF, data: 8'h00, nack: 1'b0, exp_err: 1'b0, exp_nbytes: 3, exp_busy: 5800};
    tbl[3] = '{addr: 8'h5A, data: 8'hC3, nack: 1'b0, exp_err: 1'b0, exp_nbytes: 3, exp_busy: 5800};

    // reset state
    cycles(3);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", wr_done, 0);
    check("rst_ack_err", ack_err, 0);
    sys_rst_n = 1'b1;
    cycles(5);

    // table-driven writes; ack_err from a NACK must clear on the next accept
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      send(tbl[i], 1'b1);
      check("busy_after_req", busy, 1);
      check("ack_err_cleared", ack_err, 0);
      wait_done(d0, 7000);
      cycles(50);
      check("single_done", done_cnt, d0 + 1);
      check("ack_err_hold", ack_err, tbl[i].exp_err);
    end

    // second rising edge 1000 cycles into a transfer is dropped
    d0 = done_cnt;
    send(mk(8'h12, 8'hA5, 1'b0), 1'b1);
    cycles(1000);
    send(mk(8'h99, 8'h99, 1'b0), 1'b0);
    wait_done(d0, 7000);
    cycles(300);
    check("drop_busy", busy, 0);
    check("drop_done_cnt", done_cnt, d0 + 1);

    // wr_en held high gives one transfer
    d0 = done_cnt;
    slave_nack_dev = 1'b0;
    wr_addr = 8'h34;
    wr_data = 8'h56;
    exp_q.push_back(mk(8'h34, 8'h56, 1'b0));
    wr_en = 1'b1;
    cycles(20000);
    check("hold_done_cnt", done_cnt, d0 + 1);
    check("hold_busy", busy, 0);
    wr_en = 1'b0;
    cycles(5);

    // reset during SEND_ADDR aborts without STOP
    send(mk(8'h77, 8'h66, 1'b0), 1'b1);
    n = 0;
    while (!(in_xfer && nbytes == 1 && bitidx >= 3) && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("reach_send_addr", (in_xfer && nbytes == 1 && bitidx >= 3), 1);
    s0 = stop_cnt;
    d0 = done_cnt;
    sys_rst_n = 1'b0;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda, 1);
    check("abort_busy", busy, 0);
    exp_q.delete();
    cycles(10);
    check("abort_no_stop", stop_cnt, s0);
    check("abort_no_done", done_cnt, d0);
    sys_rst_n = 1'b1;
    cycles(5);
    d0 = done_cnt;
    send(mk(8'h21, 8'h3C, 1'b0), 1'b1);
    wait_done(d0, 7000);
    cycles(50);
    check("post_rst_done", done_cnt, d0 + 1);

    check("protocol_errors", proto_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
